// File: rtl/regfile_scoreboard.sv
// Parametrised register file with per-register busy scoreboard.
// Optional write-to-read bypass enabled by defining RF_BYPASS_EN.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] io_raddr,
  output logic [NUM_RD*DATA_W-1:0] io_rdata,
  output logic [NUM_RD-1:0]        io_rbusy,
  input  logic                     io_we,
  input  logic [ADDR_W-1:0]        io_wtaddr,
  input  logic [DATA_W-1:0]        io_wtdata,
  input  logic                     io_set_busy,
  input  logic [ADDR_W-1:0]        io_set_addr,
  output logic [ADDR_W:0]          io_busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_rf [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [ADDR_W:0]   r_cnt;

  logic w_wr_ok;
  logic w_set_ok;
  logic w_same;
  logic w_inc;
  logic w_dec;

  assign w_wr_ok  = reset_n && io_we &&
                    (ZERO_REG == 0 || io_wtaddr != '0);
  assign w_set_ok = reset_n && io_set_busy &&
                    (ZERO_REG == 0 || io_set_addr != '0);
  assign w_same   = io_wtaddr == io_set_addr;

  // A retiring write on a register being re-issued keeps it busy
  assign w_inc = w_set_ok && !r_busy[io_set_addr];
  assign w_dec = w_wr_ok && r_busy[io_wtaddr] &&
                 !(w_set_ok && w_same);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_busy <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_rf[i] <= '0;
    end else begin
      if (w_wr_ok) begin
        r_rf[io_wtaddr]   <= io_wtdata;
        r_busy[io_wtaddr] <= 1'b0;
      end
      if (w_set_ok)
        r_busy[io_set_addr] <= 1'b1;
      r_cnt <= r_cnt
             + {{ADDR_W{1'b0}}, w_inc}
             - {{ADDR_W{1'b0}}, w_dec};
    end
  end

  assign io_busy_cnt = r_cnt;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_d;
    logic              w_b;

    assign w_ra = io_raddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      w_d = r_rf[w_ra];
      w_b = r_busy[w_ra];
      if (ZERO_REG != 0 && w_ra == '0) begin
        w_d = '0;
        w_b = 1'b0;
      end
`ifdef RF_BYPASS_EN
      if (w_wr_ok && w_ra == io_wtaddr) begin
        w_d = io_wtdata;
        w_b = w_set_ok && w_same;
      end
`endif
      if (!reset_n)
        w_b = 1'b0;
    end

    assign io_rdata[k*DATA_W +: DATA_W] = w_d;
    assign io_rbusy[k]                  = w_b;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed table, corner sequences,
// and random traffic against an array-based reference model.
module tb_regfile_scoreboard;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 4;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [NR*AW-1:0]  io_raddr;
  logic [NR*DW-1:0]  io_rdata;
  logic [NR-1:0]     io_rbusy;
  logic              io_we;
  logic [AW-1:0]     io_wtaddr;
  logic [DW-1:0]     io_wtdata;
  logic              io_set_busy;
  logic [AW-1:0]     io_set_addr;
  logic [AW:0]       io_busy_cnt;

  regfile_scoreboard #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .io_raddr(io_raddr),
    .io_rdata(io_rdata),
    .io_rbusy(io_rbusy),
    .io_we(io_we),
    .io_wtaddr(io_wtaddr),
    .io_wtdata(io_wtdata),
    .io_set_busy(io_set_busy),
    .io_set_addr(io_set_addr),
    .io_busy_cnt(io_busy_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] m_rf [DEPTH];
  bit            m_busy [DEPTH];

  typedef struct {
    bit          rst_n;
    bit          we;
    logic [4:0]  wa;
    logic [31:0] wd;
    bit          sb;
    logic [4:0]  sa;
    logic [4:0]  ra;
    logic [31:0] ed;
    bit          eb;
    int          ec;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit we, input int wa,
                       input logic [31:0] wd, input bit sb,
                       input int sa, input int a0, input int a1,
                       input int a2, input int a3);
    reset_n     = r;
    io_we       = we;
    io_wtaddr   = AW'(wa);
    io_wtdata   = wd;
    io_set_busy = sb;
    io_set_addr = AW'(sa);
    io_raddr    = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_rf[i]   = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (io_we && io_wtaddr != 0) begin
        m_rf[io_wtaddr]   = io_wtdata;
        m_busy[io_wtaddr] = 1'b0;
      end
      if (io_set_busy && io_set_addr != 0)
        m_busy[io_set_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic check_model();
    for (int k = 0; k < NR; k++) begin
      logic [AW-1:0] ra;
      logic [DW-1:0] ed;
      bit            eb;
      ra = io_raddr[k*AW +: AW];
      ed = (ra == 0) ? '0 : m_rf[ra];
      eb = reset_n && m_busy[ra];
`ifdef RF_BYPASS_EN
      if (reset_n && io_we && io_wtaddr != 0 && ra == io_wtaddr) begin
        ed = io_wtdata;
        eb = io_set_busy && io_set_addr == io_wtaddr;
      end
`endif
      chk($sformatf("rnd_rdata%0d", k), 64'(io_rdata[k*DW +: DW]),
          64'(ed));
      chk($sformatf("rnd_rbusy%0d", k), 64'(io_rbusy[k]), 64'(eb));
    end
    chk("rnd_cnt", 64'(io_busy_cnt), 64'(m_count()));
  endtask

  initial begin
    tbl[0]  = '{1, 1, 5, 32'hDEADBEEF, 0, 0, 1, 32'h0,        0, 0};
    tbl[1]  = '{1, 0, 0, 32'h0,        0, 0, 5, 32'hDEADBEEF, 0, 0};
    tbl[2]  = '{0, 1, 5, 32'h1,        1, 5, 5, 32'hDEADBEEF, 0, 0};
    tbl[3]  = '{1, 0, 0, 32'h0,        0, 0, 5, 32'h0,        0, 0};
    tbl[4]  = '{1, 1, 0, 32'h12345678, 0, 0, 1, 32'h0,        0, 0};
    tbl[5]  = '{1, 0, 0, 32'h0,        1, 0, 0, 32'h0,        0, 0};
    tbl[6]  = '{1, 0, 0, 32'h0,        1, 3, 0, 32'h0,        0, 0};
    tbl[7]  = '{1, 0, 0, 32'h0,        1, 7, 3, 32'h0,        1, 1};
    tbl[8]  = '{1, 0, 0, 32'h0,        1, 3, 7, 32'h0,        1, 2};
    tbl[9]  = '{1, 1, 3, 32'hA5,       0, 0, 7, 32'h0,        1, 2};
    tbl[10] = '{1, 0, 0, 32'h0,        0, 0, 3, 32'hA5,       0, 1};
    tbl[11] = '{1, 1, 9, 32'h55,       1, 9, 3, 32'hA5,       0, 1};
    tbl[12] = '{1, 1, 7, 32'h70,       1, 1, 9, 32'h55,       1, 2};
    tbl[13] = '{1, 0, 0, 32'h0,        0, 0, 7, 32'h70,       0, 2};
    tbl[14] = '{1, 0, 0, 32'h0,        1, 2, 1, 32'h0,        1, 2};
    tbl[15] = '{0, 0, 0, 32'h0,        0, 0, 2, 32'h0,        0, 3};
    tbl[16] = '{1, 0, 0, 32'h0,        0, 0, 2, 32'h0,        0, 0};
    tbl[17] = '{1, 0, 0, 32'h0,        0, 0, 9, 32'h0,        0, 0};

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_rbusy", 64'(io_rbusy), 64'(0));
    tick();
    chk("rst_cnt", 64'(io_busy_cnt), 64'(0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].we, tbl[i].wa, tbl[i].wd,
            tbl[i].sb, tbl[i].sa, tbl[i].ra, tbl[i].ra,
            tbl[i].ra, tbl[i].ra);
      #2;
      for (int k = 0; k < NR; k++) begin
        chk($sformatf("tbl%0d_rdata%0d", i, k),
            64'(io_rdata[k*DW +: DW]), 64'(tbl[i].ed));
        chk($sformatf("tbl%0d_rbusy%0d", i, k),
            64'(io_rbusy[k]), 64'(tbl[i].eb));
      end
      chk($sformatf("tbl%0d_cnt", i), 64'(io_busy_cnt),
          64'(tbl[i].ec));
      tick();
    end

    // same-cycle read of a register being written
    drive(1, 1, 4, 32'h33, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 4, 32'h77, 0, 0, 4, 4, 4, 4);
    #2;
`ifdef RF_BYPASS_EN
    chk("byp_same_cycle", 64'(io_rdata[DW-1:0]), 64'h77);
`else
    chk("byp_same_cycle", 64'(io_rdata[DW-1:0]), 64'h33);
`endif
    tick();
    drive(1, 0, 0, 0, 0, 0, 4, 4, 4, 4);
    #2;
    chk("byp_next_cycle", 64'(io_rdata[DW-1:0]), 64'h77);
    tick();

    for (int a = 1; a <= 4; a++) begin
      drive(1, 1, a, 32'(a * 'h11), 0, 0, 0, 0, 0, 0);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 1, 2, 3, 4);
    #2;
    for (int k = 0; k < NR; k++)
      chk($sformatf("mp_port%0d", k), 64'(io_rdata[k*DW +: DW]),
          64'((k + 1) * 'h11));
    tick();
    for (int a = 1; a <= 3; a++) begin
      drive(1, 0, 0, 0, 1, a, 0, 0, 0, 0);
      tick();
    end
    chk("mid_cnt3", 64'(io_busy_cnt), 64'(3));
    drive(0, 0, 0, 0, 0, 0, 1, 2, 3, 0);
    tick();
    chk("mid_rst_cnt", 64'(io_busy_cnt), 64'(0));
    chk("mid_rst_busy", 64'(io_rbusy), 64'(0));

    for (int n = 0; n < 400; n++) begin
      int wa;
      wa = int'($urandom_range(0, 15));
      drive($urandom_range(0, 39) != 0,
            $urandom_range(0, 1) == 1, wa, $urandom,
            $urandom_range(0, 1) == 1,
            ($urandom_range(0, 3) == 0) ? wa
                                        : int'($urandom_range(0, 15)),
            ($urandom_range(0, 2) == 0) ? wa
                                        : int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), wa,
            int'($urandom_range(0, 31)));
      #2;
      check_model();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
